// File: rtl/fft_addsub_pipe.sv
// ============================================================================
// Module   : fft_addsub_pipe
// Purpose  : Two-stage pipelined multi-lane signed adder/subtractor for the
//            FFT datapath. Each transaction carries LANES operand pairs, one
//            shared add/subtract select and one shared halve-with-rounding
//            select. Results are full precision (WIDTH+1 bits per lane).
//            A valid/ready handshake on both sides allows full-rate streaming
//            and lossless backpressure.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_valid   - operand transaction present
//            in_ready   - transaction accepted this cycle when in_valid=1
//            op_sub     - 0: A+B, 1: A-B
//            scale      - 1: result = round-half-up(result/2)
//            a, b       - LANES x WIDTH signed operands, lane k at [k*WIDTH+:WIDTH]
//            out_valid  - result transaction present
//            out_ready  - downstream accepts result
//            sum        - LANES x (WIDTH+1) signed results
//            busy       - either pipeline stage holds a transaction
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op_sub,
    input  logic                     scale,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*(WIDTH+1)-1:0] sum,
    output logic                     busy
);

    localparam int RW = WIDTH + 1;

    // Stage 1: registered operands and controls
    logic                   s1_valid_q, s1_valid_d;
    logic [LANES*WIDTH-1:0] s1_a_q, s1_b_q;
    logic                   s1_sub_q, s1_scale_q;

    // Stage 2: registered results
    logic                   s2_valid_q, s2_valid_d;
    logic [LANES*RW-1:0]    s2_sum_q;
    logic [LANES*RW-1:0]    w_result;

    logic                   w_s1_load;
    logic                   w_s2_load;

    // S2 takes S1's contents whenever it is empty or its current result leaves.
    assign w_s2_load = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (w_s1_load) begin
            s1_valid_d = 1'b1;
        end else if (w_s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (w_s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Per-lane arithmetic on the stage-1 registers
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [RW-1:0] w_ae;
            logic [RW-1:0] w_be;
            logic [RW-1:0] w_r;
            logic [RW-1:0] w_half;

            assign w_ae = {s1_a_q[k*WIDTH+WIDTH-1], s1_a_q[k*WIDTH +: WIDTH]};
            // Subtraction as a + ~b + 1 on the sign-extended operand.
            assign w_be = s1_sub_q ? ~{s1_b_q[k*WIDTH+WIDTH-1], s1_b_q[k*WIDTH +: WIDTH]}
                                   :  {s1_b_q[k*WIDTH+WIDTH-1], s1_b_q[k*WIDTH +: WIDTH]};
            assign w_r  = w_ae + w_be + {{(RW-1){1'b0}}, s1_sub_q};
            // (r + 1) >>> 1 equals (r >>> 1) + r[0]; this form never needs the
            // extra guard bit and cannot overflow WIDTH+1 bits.
            assign w_half = {w_r[RW-1], w_r[RW-1:1]} + {{(RW-1){1'b0}}, w_r[0]};

            assign w_result[k*RW +: RW] = s1_scale_q ? w_half : w_r;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sub_q   <= 1'b0;
            s1_scale_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (w_s1_load) begin
                s1_a_q     <= a;
                s1_b_q     <= b;
                s1_sub_q   <= op_sub;
                s1_scale_q <= scale;
            end
            if (w_s2_load) begin
                s2_sum_q <= w_result;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = s2_sum_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_addsub_pipe.sv
// ============================================================================
// Module   : tb_fft_addsub_pipe
// Purpose  : Scoreboard bench for fft_addsub_pipe (WIDTH=16, LANES=2).
//            Expected results are queued on input acceptance and compared on
//            output transfer; handshake, hold and busy behaviour are checked
//            every cycle against the number of transactions in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_addsub_pipe;

    localparam int W  = 16;
    localparam int L  = 2;
    localparam int AW = L * W;
    localparam int SW = L * (W + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic          scale;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum;
    logic          busy;

    fft_addsub_pipe #(.WIDTH(W), .LANES(L)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .scale     (scale),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    logic [SW-1:0]   sb_q[$];
    logic            hold_prev = 1'b0;
    logic [SW-1:0]   prev_sum = '0;
    logic            last_ov = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] pa(input int l0, input int l1);
        logic [W-1:0] x0, x1;
        x0 = l0[W-1:0];
        x1 = l1[W-1:0];
        return {x1, x0};
    endfunction

    function automatic logic [SW-1:0] ps(input int l0, input int l1);
        logic [W:0] x0, x1;
        x0 = l0[W:0];
        x1 = l1[W:0];
        return {x1, x0};
    endfunction

    // Reference model: integer arithmetic per lane
    function automatic logic [SW-1:0] model(input logic [AW-1:0] av, input logic [AW-1:0] bv,
                                            input bit op, input bit sc);
        logic [SW-1:0] res;
        int x, y, r;
        res = '0;
        for (int k = 0; k < L; k++) begin
            x = int'($signed(av[k*W +: W]));
            y = int'($signed(bv[k*W +: W]));
            r = op ? x - y : x + y;
            if (sc) r = (r + 1) >>> 1;
            res[k*(W+1) +: W+1] = r[W:0];
        end
        return res;
    endfunction

    // One clock cycle: drive after the falling edge, observe just before the
    // rising edge, and update the scoreboard with what that edge transfers.
    task automatic cyc(input bit iv, input logic [AW-1:0] av, input logic [AW-1:0] bv,
                       input bit op, input bit sc, input bit ordy, input logic [SW-1:0] exp);
        int n;
        logic [SW-1:0] e;
        @(negedge clk);
        in_valid  = iv;
        a         = av;
        b         = bv;
        op_sub    = op;
        scale     = sc;
        out_ready = ordy;
        #2;
        n = sb_q.size();
        chk("in_ready", in_ready, (n < 2) || ordy);
        chk("busy", busy, n != 0);
        if (hold_prev) chk("hold_sum", sum, prev_sum);
        if (out_valid && out_ready) begin
            if (n == 0) begin
                chk("unexpected_out", out_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("sum", sum, e);
            end
        end
        hold_prev = out_valid && !out_ready;
        prev_sum  = sum;
        last_ov   = out_valid;
        if (iv && in_ready) sb_q.push_back(exp);
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, ordy, '0);
    endtask

    logic [AW-1:0] ra, rb;
    bit            rop, rsc;
    int            sent;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; scale = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Add extremes, latency and single-cycle valid pulse
        cyc(1'b1, pa(32767, -32768), pa(32767, -32768), 1'b0, 1'b0, 1'b1, ps(65534, -65536));
        idle(1'b1);
        chk("lat_edge1", last_ov, 1'b0);
        idle(1'b1);
        chk("lat_edge2", last_ov, 1'b1);
        idle(1'b1);
        chk("valid_pulse", last_ov, 1'b0);

        // Subtract extremes, lanes independent
        cyc(1'b1, pa(-32768, 32767), pa(32767, -32768), 1'b1, 1'b0, 1'b1, ps(-65535, 65535));
        cyc(1'b1, pa(5, -7), pa(-3, 2), 1'b1, 1'b0, 1'b1, ps(8, -9));
        // Rounding with scale=1: sums 3,-3 / -1,1 / 0,65534
        cyc(1'b1, pa(1, -1), pa(2, -2), 1'b0, 1'b1, 1'b1, ps(2, -1));
        cyc(1'b1, pa(-1, 0), pa(0, 1), 1'b0, 1'b1, 1'b1, ps(0, 1));
        cyc(1'b1, pa(0, 32767), pa(0, 32767), 1'b0, 1'b1, 1'b1, ps(0, 32767));
        cyc(1'b1, pa(-32768, 5), pa(32767, 2), 1'b1, 1'b1, 1'b1, ps(-32767, 2));
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("directed_drained", sb_q.size(), 0);

        // Backpressure: 10 transactions, out_ready low for cycles 3..8
        sent = 0;
        for (int i = 0; i < 24; i++) begin
            ra = AW'($urandom()); rb = AW'($urandom());
            rop = 1'($urandom()); rsc = 1'($urandom());
            cyc(sent < 10, ra, rb, rop, rsc, !(i >= 3 && i <= 8), model(ra, rb, rop, rsc));
            if (in_valid && in_ready) sent++;
        end
        chk("bp_sent", sent, 10);
        chk("bp_drained", sb_q.size(), 0);

        // Asynchronous reset with both stages full
        for (int i = 0; i < 3; i++) begin
            ra = AW'($urandom()); rb = AW'($urandom());
            cyc(1'b1, ra, rb, 1'b0, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        #1;
        chk("full_before_rst", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sum", sum, '0);
        sb_q.delete();
        hold_prev = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        chk("post_rst_quiet", last_ov, 1'b0);
        cyc(1'b1, pa(100, -100), pa(23, -23), 1'b0, 1'b0, 1'b1, ps(123, -123));
        idle(1'b1);
        chk("post_rst_lat1", last_ov, 1'b0);
        idle(1'b1);
        chk("post_rst_lat2", last_ov, 1'b1);

        // Random regression
        for (int i = 0; i < 3000; i++) begin
            ra = AW'($urandom()); rb = AW'($urandom());
            rop = 1'($urandom()); rsc = 1'($urandom());
            cyc(($urandom_range(0, 3) != 0), ra, rb, rop, rsc,
                ($urandom_range(0, 3) != 0), model(ra, rb, rop, rsc));
        end
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) idle(1'b1);
        chk("final_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
